// File: rtl/matmul_ctrl.sv
// Tile-loop sequencer for the systolic-array address/operand datapath.
// Optional build macro: MATMUL_CTRL_ACC_SKIP_EN (skip RD_OUT on i==0 tiles, clear via acc_clr in WR_OUT).
//
// state    | meaning
// IDLE     | waiting for start, checks arguments
// BASE     | latch tile base addresses
// LOADW    | four weight-lane reads
// RD_IN    | four input-lane reads (h < M)
// RD_OUT   | four partial-result reads (h >= 4)
// WR_OUT   | four partial-result writes (h >= 4)
// DONE     | one-cycle job completion
module matmul_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] M,
  input  logic [8:0] N,
  input  logic [8:0] K,
  input  logic       stall,
  output logic       i_cnt,
  output logic       j_cnt,
  output logic       h_cnt,
  output logic [6:0] i_value,
  output logic [6:0] j_value,
  output logic [6:0] h_value,
  output logic       base_cal,
  output logic [1:0] sel_addr,
  output logic [1:0] off,
  output logic [1:0] w_sel,
  output logic [1:0] i_sel,
  output logic [1:0] fpo_sel,
  output logic       mem_en,
  output logic       mem_we,
  output logic       acc_clr,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef MATMUL_CTRL_ACC_SKIP_EN
  localparam logic ACC_SKIP = 1'b1;
`else
  localparam logic ACC_SKIP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_BASE, S_LOADW, S_RD_IN, S_RD_OUT, S_WR_OUT, S_DONE
  } state_t;

  state_t     state, nxt_state;
  logic [1:0] nxt_off;
  logic [6:0] nxt_h, nxt_i, nxt_j;
  logic [6:0] m_q, nt_q, kt_q;
  logic       nxt_hc, nxt_ic, nxt_jc, nxt_err, load_args, h_done, skip_rd, legal;
  logic       base_cal_q, mem_en_q, mem_we_q, h_cnt_q, i_cnt_q, j_cnt_q, done_q;

  assign legal = (M != 9'd0) && (M[1:0] == 2'b00) && (M <= 9'd120) &&
                 (N != 9'd0) && (N[1:0] == 2'b00) &&
                 (K != 9'd0) && (K[1:0] == 2'b00);
  assign skip_rd = ACC_SKIP && (i_value == 7'd0);

  always_comb begin
    nxt_state = state;
    nxt_off   = off;
    nxt_h     = h_value;
    nxt_i     = i_value;
    nxt_j     = j_value;
    nxt_hc    = 1'b0;
    nxt_ic    = 1'b0;
    nxt_jc    = 1'b0;
    nxt_err   = 1'b0;
    load_args = 1'b0;
    h_done    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (legal) begin
          nxt_state = S_BASE;
          load_args = 1'b1;
          nxt_off   = 2'd0;
          nxt_h     = 7'd0;
          nxt_i     = 7'd0;
          nxt_j     = 7'd0;
        end else begin
          nxt_err = 1'b1;
        end
      end
      S_BASE: begin
        nxt_state = S_LOADW;
        nxt_off   = 2'd0;
      end
      S_LOADW: begin
        nxt_off = off + 2'd1;
        if (off == 2'd3) nxt_state = S_RD_IN;
      end
      S_RD_IN: begin
        nxt_off = off + 2'd1;
        if (off == 2'd3) begin
          if (h_value >= 7'd4) nxt_state = skip_rd ? S_WR_OUT : S_RD_OUT;
          else h_done = 1'b1;
        end
      end
      S_RD_OUT: begin
        nxt_off = off + 2'd1;
        if (off == 2'd3) nxt_state = S_WR_OUT;
      end
      S_WR_OUT: begin
        nxt_off = off + 2'd1;
        if (off == 2'd3) h_done = 1'b1;
      end
      S_DONE: nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    // End of one h step; the tile/NEXT bookkeeping costs no extra cycle.
    if (h_done) begin
      nxt_off = 2'd0;
      if (h_value == m_q + 7'd3) begin
        nxt_h     = 7'd0;
        nxt_ic    = 1'b1;
        nxt_state = S_BASE;
        if (i_value == nt_q - 7'd1) begin
          nxt_i  = 7'd0;
          nxt_jc = 1'b1;
          if (j_value == kt_q - 7'd1) begin
            nxt_j     = 7'd0;
            nxt_state = S_DONE;
          end else begin
            nxt_j = j_value + 7'd1;
          end
        end else begin
          nxt_i = i_value + 7'd1;
        end
      end else begin
        nxt_h = h_value + 7'd1;
        if ((h_value + 7'd1) < m_q) nxt_state = S_RD_IN;
        else nxt_state = skip_rd ? S_WR_OUT : S_RD_OUT;
      end
    end

    // h_cnt marks the final cycle of the current h step.
    nxt_hc = (nxt_off == 2'd3) &&
             ((nxt_state == S_WR_OUT) || ((nxt_state == S_RD_IN) && (nxt_h < 7'd4)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      off        <= 2'd0;
      h_value    <= 7'd0;
      i_value    <= 7'd0;
      j_value    <= 7'd0;
      m_q        <= 7'd0;
      nt_q       <= 7'd0;
      kt_q       <= 7'd0;
      h_cnt_q    <= 1'b0;
      i_cnt_q    <= 1'b0;
      j_cnt_q    <= 1'b0;
      err        <= 1'b0;
      done_q     <= 1'b0;
      base_cal_q <= 1'b0;
      busy       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      sel_addr   <= 2'b00;
      w_sel      <= 2'd0;
      i_sel      <= 2'd0;
      fpo_sel    <= 2'd0;
      acc_clr    <= 1'b0;
    end else if (!(stall && state != S_IDLE)) begin
      state      <= nxt_state;
      off        <= nxt_off;
      h_value    <= nxt_h;
      i_value    <= nxt_i;
      j_value    <= nxt_j;
      if (load_args) begin
        m_q  <= M[6:0];
        nt_q <= N[8:2];
        kt_q <= K[8:2];
      end
      h_cnt_q    <= nxt_hc;
      i_cnt_q    <= nxt_ic;
      j_cnt_q    <= nxt_jc;
      err        <= nxt_err;
      done_q     <= (nxt_state == S_DONE);
      base_cal_q <= (nxt_state == S_BASE);
      busy       <= (nxt_state == S_BASE) || (nxt_state == S_LOADW) || (nxt_state == S_RD_IN) ||
                    (nxt_state == S_RD_OUT) || (nxt_state == S_WR_OUT);
      mem_en_q   <= (nxt_state == S_LOADW) || (nxt_state == S_RD_IN) ||
                    (nxt_state == S_RD_OUT) || (nxt_state == S_WR_OUT);
      mem_we_q   <= (nxt_state == S_WR_OUT);
      sel_addr   <= (nxt_state == S_RD_IN) ? 2'b01 :
                    ((nxt_state == S_RD_OUT) || (nxt_state == S_WR_OUT)) ? 2'b10 : 2'b00;
      w_sel      <= (nxt_state == S_LOADW) ? nxt_off : 2'd0;
      i_sel      <= (nxt_state == S_RD_IN) ? nxt_off : 2'd0;
      fpo_sel    <= ((nxt_state == S_RD_OUT) || (nxt_state == S_WR_OUT)) ? nxt_off : 2'd0;
      acc_clr    <= (nxt_i == 7'd0) &&
                    (ACC_SKIP ? (nxt_state == S_WR_OUT) : (nxt_state == S_RD_OUT));
    end
  end

  // A presented operation stays registered through a stall and is masked until it can issue.
  assign base_cal = base_cal_q & ~stall;
  assign mem_en   = mem_en_q & ~stall;
  assign mem_we   = mem_we_q & ~stall;
  assign h_cnt    = h_cnt_q & ~stall;
  assign i_cnt    = i_cnt_q & ~stall;
  assign j_cnt    = j_cnt_q & ~stall;
  assign done     = done_q & ~stall;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed self-checking bench for matmul_ctrl; expectations follow MATMUL_CTRL_ACC_SKIP_EN.
module tb_matmul_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stall = 1'b0;
  logic [8:0] M = 9'd4, N = 9'd4, K = 9'd4;
  logic i_cnt, j_cnt, h_cnt, base_cal, mem_en, mem_we, acc_clr, busy, done, err;
  logic [6:0] i_value, j_value, h_value;
  logic [1:0] sel_addr, off, w_sel, i_sel, fpo_sel;
  logic [40:0] outs;

  matmul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .N(N), .K(K), .stall(stall),
    .i_cnt(i_cnt), .j_cnt(j_cnt), .h_cnt(h_cnt),
    .i_value(i_value), .j_value(j_value), .h_value(h_value),
    .base_cal(base_cal), .sel_addr(sel_addr), .off(off),
    .w_sel(w_sel), .i_sel(i_sel), .fpo_sel(fpo_sel),
    .mem_en(mem_en), .mem_we(mem_we), .acc_clr(acc_clr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign outs = {i_cnt, j_cnt, h_cnt, i_value, j_value, h_value, base_cal, sel_addr, off,
                 w_sel, i_sel, fpo_sel, mem_en, mem_we, acc_clr, busy, done, err};

`ifdef MATMUL_CTRL_ACC_SKIP_EN
  localparam bit SKIP = 1'b1;
  localparam int DONE_SMALL = 38;
  localparam int DONE_TILES = 181;
  localparam int RDOUT_SMALL = 0;
`else
  localparam bit SKIP = 1'b0;
  localparam int DONE_SMALL = 54;
  localparam int DONE_TILES = 213;
  localparam int RDOUT_SMALL = 16;
`endif

  int n_cmp = 0, n_bad = 0;
  int done_cyc, n_done, n_we, n_rdout, n_hcnt, n_icnt, n_jcnt, n_err, n_acc, n_mem;
  int first_base, last_busy, loadw_bad, stall_leak, busy_at_done;
  logic [31:0] sig, exp_sig;
  int exp_mem;
  int base_i[$], base_j[$];

  function automatic logic [31:0] sig_step(logic [31:0] s, logic [25:0] e);
    return {s[26:0], s[31:27]} ^ {6'd0, e};
  endfunction

  // Reference access stream: every memory access with its indices, lane and direction.
  task automatic model(input int m, input int n, input int k, output logic [31:0] s, output int cnt);
    s = 32'd0;
    cnt = 0;
    for (int j = 0; j < k / 4; j++)
      for (int i = 0; i < n / 4; i++) begin
        for (int o = 0; o < 4; o++) begin
          s = sig_step(s, {7'(i), 7'(j), 7'd0, 2'b00, 2'(o), 1'b0}); cnt++;
        end
        for (int h = 0; h < m + 4; h++) begin
          if (h < m)
            for (int o = 0; o < 4; o++) begin
              s = sig_step(s, {7'(i), 7'(j), 7'(h), 2'b01, 2'(o), 1'b0}); cnt++;
            end
          if (h >= 4) begin
            if (!(SKIP && i == 0))
              for (int o = 0; o < 4; o++) begin
                s = sig_step(s, {7'(i), 7'(j), 7'(h), 2'b10, 2'(o), 1'b0}); cnt++;
              end
            for (int o = 0; o < 4; o++) begin
              s = sig_step(s, {7'(i), 7'(j), 7'(h), 2'b10, 2'(o), 1'b1}); cnt++;
            end
          end
        end
      end
  endtask

  task automatic run_job(input int m, input int n, input int k, input int sa, input int sl,
                         input int sb, input int sbl, input int restart, input int max_cyc);
    done_cyc = -1; n_done = 0; n_we = 0; n_rdout = 0; n_hcnt = 0; n_icnt = 0; n_jcnt = 0;
    n_err = 0; n_acc = 0; n_mem = 0; first_base = -1; last_busy = -1; loadw_bad = 0;
    stall_leak = 0; busy_at_done = 0; sig = 32'd0;
    base_i.delete(); base_j.delete();
    @(posedge clk); #1;
    M = m[8:0]; N = n[8:0]; K = k[8:0]; start = 1'b1; stall = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      start = (c == restart);
      M = (c == restart) ? 9'd6 : m[8:0];
      stall = (c >= sa && c < sa + sl) || (c >= sb && c < sb + sbl);
      #1;
      if (stall && (mem_en || mem_we || base_cal || h_cnt || i_cnt || j_cnt)) stall_leak++;
      if (mem_en) begin
        n_mem++;
        sig = sig_step(sig, {i_value, j_value, h_value, sel_addr, off, mem_we});
      end
      if (mem_we) n_we++;
      if (mem_en && sel_addr == 2'b10 && !mem_we) n_rdout++;
      if (base_cal) begin
        base_i.push_back(int'(i_value)); base_j.push_back(int'(j_value));
        if (first_base < 0) first_base = c;
      end
      if (c >= 2 && c <= 5 && !(mem_en && sel_addr == 2'b00 && off == 2'(c - 2) && w_sel == 2'(c - 2)))
        loadw_bad++;
      if (h_cnt) n_hcnt++;
      if (i_cnt) n_icnt++;
      if (j_cnt) n_jcnt++;
      if (err) n_err++;
      if (acc_clr) n_acc++;
      if (busy) last_busy = c;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        if (busy) busy_at_done++;
      end
      if (done_cyc >= 0 && c == done_cyc + 2) break;
    end
    start = 1'b0; stall = 1'b0; M = m[8:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; M = 9'd4; N = 9'd4; K = 9'd4;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (outs !== 41'd0) begin n_bad++; $display("FAIL reset_idle cyc%0d: got %h expected 0", c, outs); end
    end
  endtask

  task automatic test_smallest();
    run_job(4, 4, 4, -10, 0, -10, 0, -1, 300);
    model(4, 4, 4, exp_sig, exp_mem);
    n_cmp++; if (done_cyc != DONE_SMALL) begin n_bad++; $display("FAIL small_done: got %0d expected %0d", done_cyc, DONE_SMALL); end
    n_cmp++; if (first_base != 1) begin n_bad++; $display("FAIL small_base: got %0d expected 1", first_base); end
    n_cmp++; if (loadw_bad != 0) begin n_bad++; $display("FAIL small_loadw: got %0d bad cycles expected 0", loadw_bad); end
    n_cmp++; if (n_we != 16) begin n_bad++; $display("FAIL small_writes: got %0d expected 16", n_we); end
    n_cmp++; if (n_rdout != RDOUT_SMALL) begin n_bad++; $display("FAIL small_rdout: got %0d expected %0d", n_rdout, RDOUT_SMALL); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL small_done_width: got %0d expected 1", n_done); end
    n_cmp++; if (last_busy != DONE_SMALL - 1) begin n_bad++; $display("FAIL small_busy_end: got %0d expected %0d", last_busy, DONE_SMALL - 1); end
    n_cmp++; if (busy_at_done != 0) begin n_bad++; $display("FAIL small_busy_at_done: got %0d expected 0", busy_at_done); end
    n_cmp++; if (n_hcnt != 8) begin n_bad++; $display("FAIL small_hcnt: got %0d expected 8", n_hcnt); end
    n_cmp++; if (n_icnt != 1 || n_jcnt != 1) begin n_bad++; $display("FAIL small_ij_cnt: got %0d/%0d expected 1/1", n_icnt, n_jcnt); end
    n_cmp++; if (n_acc != 16) begin n_bad++; $display("FAIL small_acc_clr: got %0d expected 16", n_acc); end
    n_cmp++; if (n_mem != exp_mem) begin n_bad++; $display("FAIL small_accesses: got %0d expected %0d", n_mem, exp_mem); end
    n_cmp++; if (sig !== exp_sig) begin n_bad++; $display("FAIL small_sequence: got %h expected %h", sig, exp_sig); end
  endtask

  task automatic test_tiles();
    int ei[4] = '{0, 1, 0, 1};
    int ej[4] = '{0, 0, 1, 1};
    run_job(4, 8, 8, -10, 0, -10, 0, 10, 600);
    model(4, 8, 8, exp_sig, exp_mem);
    n_cmp++; if (done_cyc != DONE_TILES) begin n_bad++; $display("FAIL tiles_done: got %0d expected %0d", done_cyc, DONE_TILES); end
    n_cmp++; if (base_i.size() != 4) begin n_bad++; $display("FAIL tiles_base_count: got %0d expected 4", base_i.size()); end
    else for (int t = 0; t < 4; t++) begin
      n_cmp++;
      if (base_i[t] != ei[t] || base_j[t] != ej[t]) begin
        n_bad++; $display("FAIL tiles_order[%0d]: got (%0d,%0d) expected (%0d,%0d)", t, base_i[t], base_j[t], ei[t], ej[t]);
      end
    end
    n_cmp++; if (n_jcnt != 2) begin n_bad++; $display("FAIL tiles_jcnt: got %0d expected 2", n_jcnt); end
    n_cmp++; if (n_icnt != 4) begin n_bad++; $display("FAIL tiles_icnt: got %0d expected 4", n_icnt); end
    n_cmp++; if (n_hcnt != 32) begin n_bad++; $display("FAIL tiles_hcnt: got %0d expected 32", n_hcnt); end
    n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL tiles_start_while_busy: got %0d err expected 0", n_err); end
    n_cmp++; if (sig !== exp_sig) begin n_bad++; $display("FAIL tiles_sequence: got %h expected %h", sig, exp_sig); end
  endtask

  task automatic test_stall();
    run_job(4, 4, 4, 7, 3, 30, 2, -1, 300);
    model(4, 4, 4, exp_sig, exp_mem);
    n_cmp++; if (done_cyc != DONE_SMALL + 5) begin n_bad++; $display("FAIL stall_done: got %0d expected %0d", done_cyc, DONE_SMALL + 5); end
    n_cmp++; if (stall_leak != 0) begin n_bad++; $display("FAIL stall_leak: got %0d expected 0", stall_leak); end
    n_cmp++; if (n_we != 16) begin n_bad++; $display("FAIL stall_writes: got %0d expected 16", n_we); end
    n_cmp++; if (n_mem != exp_mem) begin n_bad++; $display("FAIL stall_accesses: got %0d expected %0d", n_mem, exp_mem); end
    n_cmp++; if (sig !== exp_sig) begin n_bad++; $display("FAIL stall_sequence: got %h expected %h", sig, exp_sig); end
  endtask

  task automatic test_illegal();
    int vm[3] = '{6, 4, 124};
    int vk[3] = '{4, 0, 4};
    for (int v = 0; v < 3; v++) begin
      int errs = 0, busys = 0;
      @(posedge clk); #1;
      M = vm[v][8:0]; N = 9'd4; K = vk[v][8:0]; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        if (err) errs++;
        if (busy) busys++;
      end
      n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL illegal_err[%0d]: got %0d expected 1", v, errs); end
      n_cmp++; if (busys != 0) begin n_bad++; $display("FAIL illegal_busy[%0d]: got %0d expected 0", v, busys); end
    end
    M = 9'd4; K = 9'd4;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(posedge clk); #1;
    M = 9'd4; N = 9'd4; K = 9'd4; start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = (c == 20 || c == 21);
      #1;
      if (done) dones++;
      if (c == 21 || c == 23) begin
        n_cmp++;
        if (outs !== 41'd0) begin n_bad++; $display("FAIL rst_mid_outputs cyc%0d: got %h expected 0", c, outs); end
      end
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
    run_job(4, 4, 4, -10, 0, -10, 0, -1, 300);
    n_cmp++; if (done_cyc != DONE_SMALL) begin n_bad++; $display("FAIL rst_mid_restart_done: got %0d expected %0d", done_cyc, DONE_SMALL); end
  endtask

  initial begin
    test_reset();
    test_smallest();
    test_tiles();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencing controller that sits directly upstream of the systolic-array address/operand datapath. It walks the 4×4 tile loops (j over output column tiles, i over reduction tiles, h over streamed rows plus drain) and drives the datapath's counter strobes, base-address latch, address-source select, lane selects and memory enables. Software starts a job with M, N, K and receives a single-cycle done.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- M, N, K  in  9 each  rows of input; reduction depth; output columns
- stall  in  1  memory back-pressure; freezes the controller
- i_cnt, j_cnt, h_cnt  out  1 each  one-cycle advance strobes for the datapath counters
- i_value, j_value, h_value  out  7 each  current loop indices
- base_cal  out  1  latch the tile base addresses
- sel_addr  out  2  address source: 00 weight, 01 input, 10 output
- off  out  2  lane offset within the tile (bi2_sel)
- w_sel, i_sel, fpo_sel  out  2 each  weight, input and PE-output lane selects
- mem_en, mem_we  out  1 each  memory access strobe and write enable
- acc_clr  out  1  forces the read-back partial result to zero
- busy, done, err  out  1 each  job active; end-of-job pulse; argument error pulse

## Operation
- Legal arguments: M, N and K are each nonzero multiples of 4, and M ≤ 120.
- On a start with illegal arguments: err pulses for 1 cycle and the controller stays in IDLE.
- Tile loops: j is the outer loop, 0..K/4−1; i is the inner loop, 0..N/4−1. For each (i,j) tile, h runs 0..M+3.
- States: IDLE → BASE → LOADW → per-h phases RD_IN, RD_OUT, WR_OUT → h-advance → NEXT → … → DONE → IDLE.
- BASE: 1 cycle. Asserts base_cal.
- LOADW: 4 cycles. sel_addr=00, mem_en=1, off=w_sel=0..3.
- RD_IN: 4 cycles, only when h<M. sel_addr=01, mem_en=1, off=i_sel=0..3.
- RD_OUT: 4 cycles, only when h≥4. sel_addr=10, mem_en=1, mem_we=0, off=fpo_sel=0..3. acc_clr=1 when i==0.
- WR_OUT: 4 cycles, only when h≥4. sel_addr=10, mem_en=1, mem_we=1, off=fpo_sel=0..3.
- After each h: h_cnt pulses and h_value increments.
- After h=M+3: h_value returns to 0. i_cnt pulses; if i wraps, j_cnt pulses. The next tile starts at BASE.
- After the last tile: DONE, which is 1 cycle with done=1, busy=0 next.
- Index arithmetic: unsigned 7-bit, never wrapping for legal arguments.
- stall=1: state, indices and off hold; mem_en, mem_we, base_cal and all strobes are forced to 0. The operation that was presented issues again on the first cycle with stall=0.
- start while busy: ignored.
- rst mid-job: on the next edge, all state and counters are aborted to IDLE, with no done pulse.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- start is accepted at cycle 0, so BASE is cycle 1.
- Outputs are registered; they are valid for the cycle they describe.
- Memory read latency is 1 cycle (the datapath registers the data). The controller does not wait on it.
- Tile cost without stalls: 5 + 12·M cycles.
- done rises at cycle 1 + Σ(tile costs) + stall cycles.
- done and err are exactly 1 cycle wide. busy is high from BASE through the last WR_OUT cycle.
- When h_cnt and i_cnt pulse together at the end of a tile, h_cnt comes first; i_cnt pulses in the following cycle, concurrent with the NEXT transition.

## Configuration
- MATMUL_CTRL_ACC_SKIP_EN defined: for tiles with i==0, the RD_OUT phase is skipped and acc_clr is held 1 during WR_OUT. Tile cost becomes 5 + 8·M. Output memory needs no pre-zeroing.
- MATMUL_CTRL_ACC_SKIP_EN undefined: RD_OUT is always performed and acc_clr is asserted there for i==0. Output memory must be pre-zeroed.

## Test plan
- Reset then idle, M=N=K=4 with no start: all outputs stay 0 for 20 cycles.
- Smallest job, M=N=K=4, start at cycle 0, no stall (macro off):
  - base_cal at cycle 1, LOADW at cycles 2–5;
  - exactly 16 writes (mem_we=1);
  - done at cycle 54.
  - With the macro on: done at cycle 38, with 0 RD_OUT reads.
- Tile sequencing, M=4, N=8, K=8: index order is (i,j) = (0,0),(1,0),(0,1),(1,1); 4 base_cal pulses and 2 j_cnt pulses; done at cycle 213 with the macro off.
- Stall injection on the smallest job: stall held 3 cycles in the middle of RD_IN and 2 cycles in WR_OUT → identical address/write sequence and done delayed by exactly 5 cycles; mem_en=0 throughout the stall.
- Illegal arguments, one start each: M=6 → err pulse; K=0 → err pulse; M=124 → err pulse. busy stays 0 in every case.
- rst asserted at cycle 20 of a running job → all outputs 0 at cycle 21, and no done. A new start at cycle 25 completes normally.
